pipe_shifter: RTL and testbench
===============================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter STAGES, default 2, register stages from input to output; legal range is 1..$clog2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush  input  1  synchronous clear of all in-flight operations.
REQ-006 SHALL have port in_valid  input  1  an operation is offered.
REQ-007 SHALL have port in_ready  output  1  the block accepts the offered operation this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  operand.
REQ-009 SHALL have port in_shamt  input  WIDTH  shift amount; only bits [$clog2(WIDTH)-1:0] are used.
REQ-010 SHALL have port in_mode  input  2  operation: 0 = SRL, 1 = SRA, 2 = SLL, 3 = ROR.
REQ-011 SHALL have port out_valid  output  1  out_data holds a result.
REQ-012 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-013 SHALL have port out_data  output  WIDTH  result.

Function
REQ-014 SHALL implement a handshake: transfer on the input side when in_valid && in_ready; on the output side when out_valid && out_ready.
REQ-015 SHALL define advance = !out_valid || out_ready; every stage moves forward by one only when advance is 1.
REQ-016 SHALL drive in_ready = advance, combinationally, with no dependency on in_valid.
REQ-017 SHALL have a latency of exactly STAGES cycles from acceptance to out_valid when there is no backpressure; throughput is one operation per cycle.
REQ-018 SHALL keep each stage's valid bit, data, residual shamt bits and mode unchanged while advance is 0 (global stall); out_data stays stable while out_valid && !out_ready.
REQ-019 SHALL decompose the shift into L = $clog2(WIDTH) levels, where level k shifts by 2^k when shamt[k] is set; level k executes in pipeline stage floor(k*STAGES/L).
REQ-020 SHALL implement SRL as zero-fill right; SRA as sign-fill right, using bit WIDTH-1 of the original operand; SLL as zero-fill left; each result is masked to WIDTH bits.
REQ-021 SHALL treat shamt = 0 as a pass-through; the ignored upper shamt bits have no effect (for example, shamt = 33 behaves as 1 when WIDTH = 32).
REQ-022 SHALL make bubbles (invalid stages) carry don't-care data, while out_data is forced to 0 whenever out_valid is 0.
REQ-023 SHALL, when flush is 1, clear all stage valid bits at the next edge regardless of advance; an input offered in the same cycle is dropped, and in_ready is still computed per REQ-016.
REQ-024 SHALL, on an accept and an output pop in the same cycle, retain the full pipeline occupancy with no lost or duplicated result.

Reset
REQ-025 SHALL, while rst_n is 0, force all stage valid bits to 0, out_valid to 0 and out_data to 0 immediately, without waiting for clk.
REQ-026 SHALL hold data and shamt pipeline registers at 0 during reset.
REQ-027 SHALL drop operations in flight when reset is asserted mid-operation; the first accept after rst_n rises produces a result after exactly STAGES cycles.
REQ-028 SHALL make in_ready 1 from the first cycle after reset, because the pipeline is empty.

Configuration
REQ-029 SHALL use macro PIPE_SHIFTER_ROTATE_EN to control rotate support.
REQ-030 SHALL, when PIPE_SHIFTER_ROTATE_EN is defined, implement mode 3 as rotate-right by shamt with no bits lost.
REQ-031 SHALL, when PIPE_SHIFTER_ROTATE_EN is not defined, execute mode 3 as SRL and synthesize no rotate logic.

Verification
REQ-032 SHALL cover latency and modes: WIDTH = 32, STAGES = 2, out_ready = 1; accept 0x80000001 with shamt = 4 in modes 0, 1 and 2 on consecutive cycles -> outputs 0x08000000, 0xF8000000 and 0x00000010 on cycles +2, +3 and +4.
REQ-033 SHALL cover rotate: with PIPE_SHIFTER_ROTATE_EN defined, mode 3, 0x0000000F, shamt = 4 -> 0xF0000000; without the macro, same stimulus -> 0x00000000.
REQ-034 SHALL cover backpressure: with the pipeline full, out_ready = 0 for 5 cycles -> in_ready = 0 and out_data stable; then out_ready = 1 -> three results in order, no gaps or duplicates.
REQ-035 SHALL cover shamt boundaries: shamt = 0 -> data passes unchanged; shamt = 31 with SRA on 0x80000000 -> 0xFFFFFFFF; shamt = 32 -> treated as 0.
REQ-036 SHALL cover flush: flush for one cycle with 2 operations in flight and in_valid = 1 -> no out_valid for those 3 operations; the next accept returns after STAGES cycles.
REQ-037 SHALL cover reset mid-operation: drop rst_n between edges while full -> out_valid = 0 and out_data = 0 immediately, in_ready = 1 after release.

Source files
------------

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL, optional ROR) with valid/ready handshake and global stall.
// Define PIPE_SHIFTER_ROTATE_EN to build mode 3 as rotate-right; otherwise mode 3 executes as SRL.

module pipe_shifter_stage #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int S      = 0,
  parameter int L      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_dat,
  input  logic [L-1:0]     prev_sh,
  input  logic [1:0]       prev_md,
  output logic             vld,
  output logic [WIDTH-1:0] dat,
  output logic [L-1:0]     sh,
  output logic [1:0]       md
);

  logic [WIDTH-1:0] nxt;

  // Only the levels mapped to this stage act; all others pass the operand through.
  // SRA reads the current MSB, which still equals the original sign after earlier levels.
  always_comb begin
    nxt = prev_dat;
    for (int k = 0; k < L; k++) begin
      if (((k * STAGES) / L == S) && prev_sh[k]) begin
        case (prev_md)
          2'd1:    nxt = $unsigned($signed(nxt) >>> (2 ** k));
          2'd2:    nxt = nxt << (2 ** k);
`ifdef PIPE_SHIFTER_ROTATE_EN
          2'd3:    nxt = (nxt >> (2 ** k)) | (nxt << (WIDTH - (2 ** k)));
`endif
          default: nxt = nxt >> (2 ** k);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
      sh  <= '0;
      md  <= '0;
    end else begin
      if (flush)    vld <= 1'b0;
      else if (adv) vld <= prev_vld;
      if (adv) begin
        dat <= nxt;
        sh  <= prev_sh;
        md  <= prev_md;
      end
    end
  end

endmodule

module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int L = $clog2(WIDTH);

  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;
  logic [STAGES:0][L-1:0]     sh_pipe;
  logic [STAGES:0][1:0]       md_pipe;
  logic                       advance;
  logic                       unused_bits;

  assign advance  = !vld_pipe[STAGES] || out_ready;
  assign in_ready = advance;

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = in_data;
  assign sh_pipe[0]  = in_shamt[L-1:0];
  assign md_pipe[0]  = in_mode;

  genvar s;
  generate
    for (s = 0; s < STAGES; s++) begin : g_stg
      pipe_shifter_stage #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .S      (s)
      ) u_stg (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .adv      (advance),
        .prev_vld (vld_pipe[s]),
        .prev_dat (dat_pipe[s]),
        .prev_sh  (sh_pipe[s]),
        .prev_md  (md_pipe[s]),
        .vld      (vld_pipe[s+1]),
        .dat      (dat_pipe[s+1]),
        .sh       (sh_pipe[s+1]),
        .md       (md_pipe[s+1])
      );
    end
  endgenerate

  // Upper shamt bits are ignored by definition; last-stage shamt/mode have no consumer.
  assign unused_bits = ^{in_shamt[WIDTH-1:L], sh_pipe[STAGES], md_pipe[STAGES]};

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = vld_pipe[STAGES] ? dat_pipe[STAGES] : '0;

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=32, STAGES=2): directed vectors, latency,
// backpressure, flush and mid-operation reset.
module tb_pipe_shifter;

  localparam int W   = 32;
  localparam int STG = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_shamt = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;

  typedef struct {
    logic [W-1:0] d;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  pipe_shifter #(.WIDTH(W), .STAGES(STG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected results on every output transfer.
  always @(negedge clk) begin
    if (!out_valid) chk("idle_out_data_zero", out_data, '0);
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("result", out_data, x.d);
        if (x.cyc >= 0) chk("latency_cycle", W'(cyc), W'(x.cyc));
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [W-1:0] s, input logic [1:0] m,
                      input logic [W-1:0] e, input bit lat);
    bit ok;
    exp_t x;
    ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        x.d = e;
        x.cyc = lat ? cyc + STG : -1;
        q.push_back(x);
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  logic [W-1:0] rot_exp0, rot_exp1;

  initial begin
`ifdef PIPE_SHIFTER_ROTATE_EN
    rot_exp0 = 32'hF000_0000;
    rot_exp1 = 32'h7812_3456;
`else
    rot_exp0 = 32'h0000_0000;
    rot_exp1 = 32'h0012_3456;
`endif
    // Reset state
    #3;
    chk("reset_out_valid", W'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;

    // Latency and modes, consecutive accepts
    send(32'h8000_0001, 4, 2'd0, 32'h0800_0000, 1'b1);
    send(32'h8000_0001, 4, 2'd1, 32'hF800_0000, 1'b1);
    send(32'h8000_0001, 4, 2'd2, 32'h0000_0010, 1'b1);
    // Rotate and shamt boundaries, plus level mixing
    send(32'h0000_000F, 4,  2'd3, rot_exp0,       1'b1);
    send(32'h1234_5678, 8,  2'd3, rot_exp1,       1'b1);
    send(32'hDEAD_BEEF, 0,  2'd1, 32'hDEAD_BEEF, 1'b1);
    send(32'h8000_0000, 31, 2'd1, 32'hFFFF_FFFF, 1'b1);
    send(32'h1234_5678, 32, 2'd0, 32'h1234_5678, 1'b1);
    send(32'h1234_5678, 33, 2'd2, 32'h2468_ACF0, 1'b1);
    send(32'h7FFF_FFF0, 4,  2'd1, 32'h07FF_FFFF, 1'b1);
    send(32'h0000_0003, 31, 2'd2, 32'h8000_0000, 1'b1);
    send(32'hABCD_1234, 16, 2'd0, 32'h0000_ABCD, 1'b1);
    send(32'hF0F0_F0F0, 7,  2'd0, 32'h01E1_E1E1, 1'b1);
    idle();
    repeat (4) @(posedge clk); #1;

    // Backpressure: fill, stall 5 cycles, release
    out_ready = 1'b0;
    send(32'h0000_0100, 4, 2'd0, 32'h0000_0010, 1'b0);
    send(32'h0000_0100, 8, 2'd0, 32'h0000_0001, 1'b0);
    in_valid = 1'b1; in_data = 32'h0000_0100; in_shamt = 1; in_mode = 2'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", W'(in_ready), 0);
      chk("stall_out_valid", W'(out_valid), 1);
      chk("stall_out_data", out_data, 32'h0000_0010);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h0000_0100, 1, 2'd2, 32'h0000_0200, 1'b0);
    idle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("release_no_gap", W'(out_valid), 1);
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk); #1;

    // Flush with pipeline full and an input offered
    out_ready = 1'b0;
    send(32'h1111_1111, 1, 2'd0, 32'h0888_8888, 1'b0);
    send(32'h2222_2222, 1, 2'd0, 32'h1111_1111, 1'b0);
    in_valid = 1'b1; in_data = 32'h3333_3333; in_shamt = 0; in_mode = 2'd0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_no_out_valid", W'(out_valid), 0);
      chk("flush_in_ready", W'(in_ready), 1);
      @(posedge clk); #1;
    end
    // Flush with empty pipe and in_ready=1: offered input must be dropped
    in_valid = 1'b1; in_data = 32'h4444_4444; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_drop_input", W'(out_valid), 0);
      @(posedge clk); #1;
    end
    send(32'h0000_00F0, 4, 2'd0, 32'h0000_000F, 1'b1);
    idle();
    repeat (3) @(posedge clk); #1;

    // Reset mid-operation
    out_ready = 1'b0;
    send(32'h5555_5555, 0, 2'd0, 32'h5555_5555, 1'b0);
    send(32'h6666_6666, 0, 2'd0, 32'h6666_6666, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", W'(out_valid), 0);
    chk("async_reset_out_data", out_data, '0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("reset_release_in_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    send(32'h8000_0000, 3, 2'd1, 32'hF000_0000, 1'b1);
    idle();

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", W'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
